// File: rtl/ascon_ct_decrypt.sv
// ASCON-128 receive side: absorbs ciphertext, emits plaintext, then finalizes and checks the tag.
// Define ASCON_DEC_2ROUND_EN to unroll two permutation rounds per cycle (default: one round per cycle).
module ascon_ct_decrypt (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  x0,
  input  logic [63:0]  x1,
  input  logic [63:0]  x2,
  input  logic [63:0]  x3,
  input  logic [63:0]  x4,
  input  logic [127:0] key,
  input  logic [127:0] tag_in,
  input  logic [63:0]  ct_data,
  input  logic [3:0]   ct_bytes,
  input  logic         ct_last,
  input  logic         ct_valid,
  output logic         ct_ready,
  output logic [63:0]  pt_data,
  output logic [3:0]   pt_bytes,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic         busy,
  output logic         done,
  output logic         auth_ok
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABSORB = 3'd1,
    EMIT   = 3'd2,
    PERM6  = 3'd3,
    FINAL  = 3'd4,
    DONE   = 3'd5
  } state_t;

`ifdef ASCON_DEC_2ROUND_EN
  localparam logic [3:0] RND_STEP = 4'd2;
  localparam logic [3:0] RND_LAST = 4'd10;
`else
  localparam logic [3:0] RND_STEP = 4'd1;
  localparam logic [3:0] RND_LAST = 4'd11;
`endif

  // One ASCON round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    a0 = s[319:256];
    a1 = s[255:192];
    a2 = s[191:128] ^ {56'd0, 4'd15 - r, r};
    a3 = s[127:64];
    a4 = s[63:0];
    a0 = a0 ^ a4;  a4 = a4 ^ a3;  a2 = a2 ^ a1;
    t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
    a0 = a0 ^ t1;  a1 = a1 ^ t2;  a2 = a2 ^ t3;  a3 = a3 ^ t4;  a4 = a4 ^ t0;
    a1 = a1 ^ a0;  a0 = a0 ^ a4;  a3 = a3 ^ a2;  a2 = ~a2;
    a0 = a0 ^ {a0[18:0], a0[63:19]} ^ {a0[27:0], a0[63:28]};
    a1 = a1 ^ {a1[60:0], a1[63:61]} ^ {a1[38:0], a1[63:39]};
    a2 = a2 ^ {a2[0],    a2[63:1]}  ^ {a2[5:0],  a2[63:6]};
    a3 = a3 ^ {a3[9:0],  a3[63:10]} ^ {a3[16:0], a3[63:17]};
    a4 = a4 ^ {a4[6:0],  a4[63:7]}  ^ {a4[40:0], a4[63:41]};
    return {a0, a1, a2, a3, a4};
  endfunction

  state_t         state_r, state_s;
  logic [63:0]    x0_r, x1_r, x2_r, x3_r, x4_r;
  logic [127:0]   key_r, tag_r;
  logic [3:0]     rnd_r;
  logic           last_r, full_last_r;
  logic [63:0]    pt_data_r;
  logic [3:0]     pt_bytes_r;
  logic           auth_ok_r;

  logic [3:0]     lsat_s;
  logic           blast_s;
  logic [63:0]    mask_s, pad_s, ct_pt_s, ct_x0_s;
  logic           fold_s, last_rnd_s;
  logic [319:0]   perm_in_s, perm_out_s;
  logic [127:0]   fin_tag_s;

  // Absorb datapath: saturate the byte count, build the byte mask and padding.
  always_comb begin
    if (ct_bytes > 4'd8) begin
      lsat_s = 4'd8;
    end else begin
      lsat_s = ct_bytes;
    end
    blast_s = ct_last || (lsat_s != 4'd8);
    mask_s  = ~(64'hFFFF_FFFF_FFFF_FFFF >> {lsat_s, 3'b000});
    if (lsat_s != 4'd8) begin
      pad_s = 64'h0000_0000_0000_0080 << (7'd56 - {lsat_s, 3'b000});
    end else begin
      pad_s = 64'd0;
    end
    ct_pt_s = (x0_r ^ ct_data) & mask_s;
    ct_x0_s = ((ct_data & mask_s) | (x0_r & ~mask_s)) ^ pad_s;
  end

  // Permutation input; the finalization key XOR is folded into round 0.
  always_comb begin
    fold_s     = (state_r == FINAL) && (rnd_r == 4'd0);
    last_rnd_s = (rnd_r == RND_LAST);
    if (fold_s) begin
      perm_in_s = {x0_r, x1_r ^ key_r[127:64], x2_r ^ key_r[63:0], x3_r, x4_r};
    end else begin
      perm_in_s = {x0_r, x1_r, x2_r, x3_r, x4_r};
    end
  end

`ifdef ASCON_DEC_2ROUND_EN
  assign perm_out_s = ascon_round(ascon_round(perm_in_s, rnd_r), rnd_r + 4'd1);
`else
  assign perm_out_s = ascon_round(perm_in_s, rnd_r);
`endif

  assign fin_tag_s = perm_out_s[127:0] ^ key_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = ABSORB;
        else       state_s = IDLE;
      end
      ABSORB: begin
        if (!ct_valid)              state_s = ABSORB;
        else if (lsat_s == 4'd0)    state_s = FINAL;
        else                        state_s = EMIT;
      end
      EMIT: begin
        if (!pt_ready)                    state_s = EMIT;
        else if (last_r && !full_last_r)  state_s = FINAL;
        else                              state_s = PERM6;
      end
      PERM6: begin
        if (!last_rnd_s)       state_s = PERM6;
        else if (full_last_r)  state_s = FINAL;
        else                   state_s = ABSORB;
      end
      FINAL: begin
        if (last_rnd_s) state_s = DONE;
        else            state_s = FINAL;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    ct_ready = 1'b0;
    pt_valid = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state_r)
      IDLE:    busy     = 1'b0;
      ABSORB:  ct_ready = 1'b1;
      EMIT:    pt_valid = 1'b1;
      DONE:    done     = 1'b1;
      default: busy     = 1'b1;
    endcase
  end

  // Sponge state, round counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0_r <= 64'd0; x1_r <= 64'd0; x2_r <= 64'd0; x3_r <= 64'd0; x4_r <= 64'd0;
      key_r       <= 128'd0;
      tag_r       <= 128'd0;
      rnd_r       <= 4'd0;
      last_r      <= 1'b0;
      full_last_r <= 1'b0;
      pt_data_r   <= 64'd0;
      pt_bytes_r  <= 4'd0;
      auth_ok_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            x0_r <= x0; x1_r <= x1; x2_r <= x2; x3_r <= x3; x4_r <= x4;
            key_r       <= key;
            tag_r       <= tag_in;
            rnd_r       <= 4'd0;
            last_r      <= 1'b0;
            full_last_r <= 1'b0;
            auth_ok_r   <= 1'b0;
          end
        end
        ABSORB: begin
          if (ct_valid) begin
            x0_r        <= ct_x0_s;
            pt_data_r   <= ct_pt_s;
            pt_bytes_r  <= lsat_s;
            last_r      <= blast_s;
            full_last_r <= blast_s && (lsat_s == 4'd8);
            rnd_r       <= 4'd0;
          end
        end
        EMIT: begin
          if (pt_ready) begin
            rnd_r <= (state_s == PERM6) ? 4'd6 : 4'd0;
          end
        end
        PERM6: begin
          {x0_r, x1_r, x2_r, x3_r, x4_r} <= perm_out_s;
          if (last_rnd_s) begin
            rnd_r <= 4'd0;
            // A full final block is followed by an implicit empty padded block.
            if (full_last_r) begin
              x0_r <= perm_out_s[319:256] ^ {8'h80, 56'd0};
            end
          end else begin
            rnd_r <= rnd_r + RND_STEP;
          end
        end
        FINAL: begin
          {x0_r, x1_r, x2_r} <= perm_out_s[319:128];
          if (last_rnd_s) begin
            {x3_r, x4_r} <= fin_tag_s;
            auth_ok_r    <= (fin_tag_s == tag_r);
            rnd_r        <= 4'd0;
          end else begin
            {x3_r, x4_r} <= perm_out_s[127:0];
            rnd_r        <= rnd_r + RND_STEP;
          end
        end
        default: begin
          rnd_r <= rnd_r;
        end
      endcase
    end
  end

  assign pt_data  = pt_data_r;
  assign pt_bytes = pt_bytes_r;
  assign auth_ok  = auth_ok_r;

endmodule
